// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The master issues operations; the slave (the subtractor) reports status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    // Handshake: start is taken only while the slave is idle or done (busy=0).
    // An accepted start captures a/b/bin on that edge. busy stays high for
    // WIDTH cycles, then done pulses for one cycle with d/bout valid, and
    // d/bout hold until the next completion or reset.
    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = a - b - bin, one bit per clock, LSB first,
// with a borrow flip-flop and a start/done handshake for back-to-back issue.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus,
    output logic [1:0]           state_dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             diff_bit;
    logic             next_br;
    logic [WIDTH-1:0] sd_next;

    // Full-subtractor cell on the current LSBs.
    assign x        = sa[0];
    assign y        = sb[0];
    assign diff_bit = x ^ y ^ br;
    assign next_br  = (~x & y) | (~(x ^ y) & br);
    assign sd_next  = {diff_bit, sd[WIDTH-1:1]};

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            sd       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.d    <= '0;
            bus.bout <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sa       <= bus.a;
                        sb       <= bus.b;
                        br       <= bus.bin;
                        sd       <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_next;
                    br  <= next_br;
                    cnt <= cnt + 1'b1;
                    // Last bit: publish the result including this cycle's bit.
                    if (cnt == LAST) begin
                        bus.d    <= sd_next;
                        bus.bout <= next_br;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor. It computes `d = a - b - bin`, one bit per clock, LSB first, using a registered full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the team's full-adder datapath cells. It sits behind a start/done handshake so a controller can issue operations back-to-back.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a new operation; sampled only when the block can accept (IDLE or DONE).
- `a` input WIDTH: minuend; captured on the accepted start edge.
- `b` input WIDTH: subtrahend; captured on the accepted start edge.
- `bin` input 1: borrow-in; captured on the accepted start edge.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; result is valid from this cycle onward.
- `d` output WIDTH: difference; holds the last completed result.
- `bout` output 1: final borrow-out; 1 when `a < b + bin` (unsigned); held with `d`.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - `start=1` moves to RUN.
  - Loads shift registers `sa<=a`, `sb<=b`, borrow FF `br<=bin`, bit counter `cnt<=0`.
- RUN, one bit per cycle:
  - `x=sa[0]`, `y=sb[0]`.
  - Difference bit `x^y^br`.
  - Next borrow `(~x&y) | (~(x^y)&br)`.
  - The difference bit shifts into the MSB of the working register `sd` (right shift). `sa` and `sb` shift right.
  - `cnt` increments.
  - When the cycle with `cnt==WIDTH-1` completes, the next state is DONE.
- Transition into DONE:
  - `d` gets the final `sd`, including the last bit.
  - `bout` gets the final borrow.
  - `d` and `bout` change only on this transition.
- DONE:
  - `done=1` for exactly this cycle.
  - `start=1` moves to RUN with a fresh capture (back-to-back); `start=0` moves to IDLE.
- `start` during RUN is ignored. No queuing; operands on `a`/`b` are not resampled.
- Operand inputs matter only on the accepted start edge.
- Width rule: the result is modulo 2^WIDTH; `bout` is the borrow out of bit WIDTH-1.
- `cnt` width is `$clog2(WIDTH)`; it must not wrap before the transition to DONE.

## Timing
- Reset (`rst=1` at a rising edge):
  - State goes to IDLE.
  - `busy=0`, `done=0`, `d=0`, `bout=0`, `br=0`, `cnt=0`.
  - Reset has priority over `start` on the same edge.
- Reset mid-RUN aborts the operation. `d` and `bout` clear to 0 and no `done` pulse is issued.
- Latency: start is accepted at edge E; RUN occupies the cycles after edges E..E+WIDTH-1; `done=1` in the cycle after edge E+WIDTH.
  - That is, WIDTH+1 cycles from the accepted-start edge to `done` high, counting the start cycle.
- `busy` is high for exactly WIDTH consecutive cycles per operation and low in DONE.
- Throughput with back-to-back starts is one result every WIDTH+1 cycles.
- `d` and `bout` update in the same cycle `done` rises and are stable until the next DONE entry or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, `a=0x5A`, `b=0x3C`, `bin=0`, one start pulse -> after 9 cycles `done=1`, `d=0x1E`, `bout=0`; `busy` high for exactly 8 cycles.
- `a=0x10`, `b=0x20`, `bin=0` -> `d=0xF0`, `bout=1`. Also `a=0x00`, `b=0x00`, `bin=1` -> `d=0xFF`, `bout=1`.
- `a=0xFF`, `b=0xFF`, `bin=0` -> `d=0x00`, `bout=0`. Then `a=0x80`, `b=0x01`, `bin=1` -> `d=0x7E`, `bout=0`.
- Start ignored while busy: start `0x5A-0x3C`, then pulse start with `a=0x00`, `b=0x01` at cycle 3 of RUN -> single result `d=0x1E`, one `done` pulse only.
- Back-to-back: hold `start=1` continuously with alternating operand pairs -> `done` pulses every 9 cycles, each with the correct `d`/`bout`; `busy` low only during DONE cycles.
- Reset mid-operation: assert `rst` at RUN cycle 4 -> next cycle `busy=0`, `done=0`, `d=0`, `bout=0`. A fresh start afterward completes correctly in 9 cycles. `rst` and `start` on the same edge -> stays IDLE.
